// File: rtl/apb_arb2_if.sv
// APB request/response bundle shared by both requesters and the downstream master port.
// The master modport drives the request side; the slave modport returns the response.
interface apb_arb2_if;
    logic        psel;
    logic        penable;
    logic [15:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot, pwrite, pstrb, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_arb2.sv
// Two-requester round-robin APB arbiter in front of a single APB completer.
// Define APB_ARB2_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT cycles.
//
// state  | meaning
// IDLE   | arbitrate; latch winner's request fields
// SETUP  | m_psel=1, m_penable=0 for one cycle
// ACCESS | m_psel=1, m_penable=1 until m_pready (or timeout)
// RESP   | one-cycle pready pulse to the owner
module apb_arb2 #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    apb_arb2_if.slave   s0,
    apb_arb2_if.slave   s1,
    apb_arb2_if.master  m,
    output logic [1:0]  grant,
    output logic        busy,
    output logic [31:0] xfer_count,
    output logic [31:0] timeout_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic        m_psel_q, m_psel_d;
    logic        m_penable_q, m_penable_d;
    logic [15:0] m_paddr_q, m_paddr_d;
    logic [2:0]  m_pprot_q, m_pprot_d;
    logic        m_pwrite_q, m_pwrite_d;
    logic [3:0]  m_pstrb_q, m_pstrb_d;
    logic [31:0] m_pwdata_q, m_pwdata_d;
    logic [1:0]  pready_q, pready_d;
    logic [31:0] prdata0_q, prdata0_d;
    logic [31:0] prdata1_q, prdata1_d;
    logic        pslverr0_q, pslverr0_d;
    logic        pslverr1_q, pslverr1_d;
    logic [31:0] xfer_q, xfer_d;

    logic        pick0, pick1;
    logic        done;
    logic [31:0] rd_data;
    logic        rd_err;

`ifdef APB_ARB2_TIMEOUT_EN
    logic [31:0] timer_q, timer_d;
    logic [31:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        m_psel_d    = m_psel_q;
        m_penable_d = m_penable_q;
        m_paddr_d   = m_paddr_q;
        m_pprot_d   = m_pprot_q;
        m_pwrite_d  = m_pwrite_q;
        m_pstrb_d   = m_pstrb_q;
        m_pwdata_d  = m_pwdata_q;
        pready_d    = 2'b00;
        prdata0_d   = prdata0_q;
        prdata1_d   = prdata1_q;
        pslverr0_d  = pslverr0_q;
        pslverr1_d  = pslverr1_q;
        xfer_d      = xfer_q;
        done        = 1'b0;
        rd_data     = m.prdata;
        rd_err      = m.pslverr;
`ifdef APB_ARB2_TIMEOUT_EN
        timer_d     = timer_q;
        tmo_d       = tmo_q;
`endif
        // last_q=1 means s1 was served last, so s0 wins a tie
        pick0 = s0.psel & (~s1.psel | last_q);
        pick1 = s1.psel & ~pick0;

        case (state_q)
            IDLE: begin
                if (pick0 | pick1) begin
                    state_d    = SETUP;
                    grant_d    = {pick1, pick0};
                    last_d     = pick1;
                    m_psel_d   = 1'b1;
                    m_paddr_d  = pick0 ? s0.paddr  : s1.paddr;
                    m_pprot_d  = pick0 ? s0.pprot  : s1.pprot;
                    m_pwrite_d = pick0 ? s0.pwrite : s1.pwrite;
                    m_pstrb_d  = pick0 ? s0.pstrb  : s1.pstrb;
                    m_pwdata_d = pick0 ? s0.pwdata : s1.pwdata;
                end
            end
            SETUP: begin
                state_d     = ACCESS;
                m_penable_d = 1'b1;
`ifdef APB_ARB2_TIMEOUT_EN
                timer_d     = 32'(TIMEOUT - 1);
`endif
            end
            ACCESS: begin
                if (m.pready) begin
                    done   = 1'b1;
                    xfer_d = xfer_q + 32'd1;
                end
`ifdef APB_ARB2_TIMEOUT_EN
                else if (timer_q == '0) begin
                    done    = 1'b1;
                    rd_data = 32'hDEAD_BEEF;
                    rd_err  = 1'b1;
                    tmo_d   = tmo_q + 32'd1;
                end
                else begin
                    timer_d = timer_q - 32'd1;
                end
`endif
                if (done) begin
                    state_d     = RESP;
                    m_psel_d    = 1'b0;
                    m_penable_d = 1'b0;
                    pready_d    = grant_q;
                    if (grant_q[0]) begin
                        prdata0_d  = rd_data;
                        pslverr0_d = rd_err;
                    end else begin
                        prdata1_d  = rd_data;
                        pslverr1_d = rd_err;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_paddr_q   <= '0;
            m_pprot_q   <= '0;
            m_pwrite_q  <= 1'b0;
            m_pstrb_q   <= '0;
            m_pwdata_q  <= '0;
            pready_q    <= 2'b00;
            prdata0_q   <= '0;
            prdata1_q   <= '0;
            pslverr0_q  <= 1'b0;
            pslverr1_q  <= 1'b0;
            xfer_q      <= '0;
`ifdef APB_ARB2_TIMEOUT_EN
            timer_q     <= '0;
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            m_paddr_q   <= m_paddr_d;
            m_pprot_q   <= m_pprot_d;
            m_pwrite_q  <= m_pwrite_d;
            m_pstrb_q   <= m_pstrb_d;
            m_pwdata_q  <= m_pwdata_d;
            pready_q    <= pready_d;
            prdata0_q   <= prdata0_d;
            prdata1_q   <= prdata1_d;
            pslverr0_q  <= pslverr0_d;
            pslverr1_q  <= pslverr1_d;
            xfer_q      <= xfer_d;
`ifdef APB_ARB2_TIMEOUT_EN
            timer_q     <= timer_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign m.psel     = m_psel_q;
    assign m.penable  = m_penable_q;
    assign m.paddr    = m_paddr_q;
    assign m.pprot    = m_pprot_q;
    assign m.pwrite   = m_pwrite_q;
    assign m.pstrb    = m_pstrb_q;
    assign m.pwdata   = m_pwdata_q;

    assign s0.pready  = pready_q[0];
    assign s1.pready  = pready_q[1];
    assign s0.prdata  = prdata0_q;
    assign s1.prdata  = prdata1_q;
    assign s0.pslverr = pslverr0_q;
    assign s1.pslverr = pslverr1_q;

    assign grant      = grant_q;
    assign busy       = (state_q != IDLE);
    assign xfer_count = xfer_q;

`ifdef APB_ARB2_TIMEOUT_EN
    assign timeout_count = tmo_q;
`else
    assign timeout_count = '0;
`endif

    // requester penable carries no information once psel is seen
    logic unused_in;
    assign unused_in = s0.penable ^ s1.penable ^ (TIMEOUT == 0);

endmodule
